// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and FSM state type for the seven-segment serialiser
package seg_pkg;

    localparam int SEG_BITS   = 64;
    localparam int SEG_DIGITS = 8;
    localparam int SEG_CNT_W  = $clog2(SEG_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } seg_state_e;

endpackage

// File: rtl/clk_tick_gen.sv
// rtl/clk_tick_gen.sv - divider producing a half-period tick every CLK_DIV enabled cycles
module clk_tick_gen
    import seg_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic half_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign half_tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || half_tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_p2s.sv
// rtl/seg_p2s.sv - MSB-first serialiser driving the 8-digit seven-segment shift-register chain
module seg_p2s
    import seg_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int SEG_BITS = seg_pkg::SEG_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SEG_BITS-1:0] seg_txt,
    output logic                busy,
    output logic                done,
    output logic                seg_clk,
    output logic                seg_dat,
    output logic                seg_pen
);

    localparam int CNT_W = $clog2(SEG_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SEG_BITS - 1);

    seg_state_e          state;
    logic [SEG_BITS-1:0] shreg;
    logic [CNT_W-1:0]    bit_cnt;
    logic                load;
    logic                half_tick;

    assign load = (state == ST_IDLE) && start;

    clk_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (load),
        .en       (state == ST_SHIFT),
        .half_tick(half_tick)
    );

    // Data is the register MSB itself, so it only moves on the falling seg_clk step.
    assign seg_dat = shreg[SEG_BITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            seg_clk <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            seg_pen <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shreg   <= seg_txt;
                        bit_cnt <= '0;
                        seg_clk <= 1'b0;
                        busy    <= 1'b1;
                        seg_pen <= 1'b0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (half_tick) begin
                        if (!seg_clk) begin
                            seg_clk <= 1'b1;
                        end else begin
                            seg_clk <= 1'b0;
                            shreg   <= {shreg[SEG_BITS-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state   <= ST_LATCH;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                seg_pen <= 1'b1;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_p2s.sv
// tb/tb_seg_p2s.sv - self-checking bench for seg_p2s against a timing-level reference model
module tb_seg_p2s;

    logic        clk;
    logic        rst_n;
    logic        start0, start1;
    logic [63:0] txt0, txt1;
    logic        busy0, done0, sclk0, sdat0, pen0;
    logic        busy1, done1, sclk1, sdat1, pen1;

    int errors = 0;
    int checks = 0;

    seg_p2s #(.CLK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .seg_txt(txt0),
        .busy(busy0), .done(done0), .seg_clk(sclk0), .seg_dat(sdat0), .seg_pen(pen0)
    );

    seg_p2s #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .seg_txt(txt1),
        .busy(busy1), .done(done1), .seg_clk(sclk1), .seg_dat(sdat1), .seg_pen(pen1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic samp(input int which, output logic c, output logic d,
                        output logic b, output logic dn, output logic p);
        if (which == 0) begin
            c = sclk0; d = sdat0; b = busy0; dn = done0; p = pen0;
        end else begin
            c = sclk1; d = sdat1; b = busy1; dn = done1; p = pen1;
        end
    endtask

    task automatic set_in(input int which, input logic s, input logic [63:0] w);
        if (which == 0) begin
            start0 = s; txt0 = w;
        end else begin
            start1 = s; txt1 = w;
        end
    endtask

    // Must be entered at a falling clk edge; start is sampled on the next rising edge.
    // mode 0: plain, 1: extra starts at bit 20 and in the done cycle, 2: seg_txt scrambled each cycle
    task automatic run_word(input int which, input int div, input logic [63:0] w,
                            input int mode, input int tail, input string tag);
        logic [63:0] cap;
        logic        c, d, b, dn, p, pc, exp_clk, exp_dat, in_shift;
        int          rises, first_rise, done_cnt;
        int          busy_bad, done_bad, pen_bad, clk_bad, dat_bad;
        int          shift_len, last;
        shift_len = 128 * div;
        last = shift_len + 1 + tail;
        cap = '0; rises = 0; first_rise = -1; done_cnt = 0;
        busy_bad = 0; done_bad = 0; pen_bad = 0; clk_bad = 0; dat_bad = 0;
        pc = 1'b0;
        set_in(which, 1'b1, w);
        @(posedge clk);
        #1 set_in(which, 1'b0, w);
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            samp(which, c, d, b, dn, p);
            in_shift = (n <= shift_len);
            exp_clk  = in_shift && (((n - 1) % (2 * div)) >= div);
            exp_dat  = in_shift ? w[63 - (n - 1) / (2 * div)] : 1'b0;
            if (c === 1'b1 && pc !== 1'b1) begin
                rises++;
                cap = {cap[62:0], d};
                if (first_rise < 0) first_rise = n;
            end
            pc = c;
            if (b !== in_shift) busy_bad++;
            if (dn !== (n == shift_len + 1)) done_bad++;
            if (dn === 1'b1) done_cnt++;
            if (p !== !in_shift) pen_bad++;
            if (c !== exp_clk) clk_bad++;
            if (d !== exp_dat) dat_bad++;
            if (mode == 1) begin
                if (n == 1 + 40 * div || n == shift_len + 1)
                    set_in(which, 1'b1, 64'h1234_5678_9ABC_DEF0);
                else
                    set_in(which, 1'b0, 64'h1234_5678_9ABC_DEF0);
            end else if (mode == 2) begin
                set_in(which, 1'b0, {$urandom, $urandom});
            end
        end
        if (mode != 0) set_in(which, 1'b0, w);
        checks++; if (rises !== 64) begin errors++; $display("FAIL %s rises: got %0d want 64", tag, rises); end
        checks++; if (cap !== w) begin errors++; $display("FAIL %s word: got %h want %h", tag, cap, w); end
        checks++; if (first_rise !== div + 1) begin errors++; $display("FAIL %s first_rise: got %0d want %0d", tag, first_rise, div + 1); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", tag, done_cnt); end
        checks++; if (busy_bad !== 0) begin errors++; $display("FAIL %s busy_timing: got %0d bad cycles want 0", tag, busy_bad); end
        checks++; if (done_bad !== 0) begin errors++; $display("FAIL %s done_timing: got %0d bad cycles want 0", tag, done_bad); end
        checks++; if (pen_bad !== 0) begin errors++; $display("FAIL %s pen_timing: got %0d bad cycles want 0", tag, pen_bad); end
        checks++; if (clk_bad !== 0) begin errors++; $display("FAIL %s seg_clk_wave: got %0d bad cycles want 0", tag, clk_bad); end
        checks++; if (dat_bad !== 0) begin errors++; $display("FAIL %s seg_dat_wave: got %0d bad cycles want 0", tag, dat_bad); end
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        rst_n = 1'b0;
        set_in(0, 1'b0, '0);
        set_in(1, 1'b0, '0);
        repeat (3) @(negedge clk);
        outs = {busy0, done0, sclk0, sdat0, pen0, busy1, done1, sclk1, sdat1, pen1};
        checks++; if (outs !== 10'b0) begin errors++; $display("FAIL reset_outputs: got %b want %b", outs, 10'b0); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        outs = {busy0, done0, sclk0, sdat0, pen0, busy1, done1, sclk1, sdat1, pen1};
        checks++; if (outs !== 10'b0) begin errors++; $display("FAIL idle_after_reset: got %b want %b", outs, 10'b0); end
    endtask

    task automatic test_marker();
        @(negedge clk);
        run_word(0, 2, 64'h8000_0000_0000_0001, 0, 3, "marker");
    endtask

    task automatic test_typical();
        @(negedge clk);
        run_word(0, 2, 64'hA5A5_A5A5_A5A5_A5A5, 0, 3, "typical");
    endtask

    task automatic test_ignored_start();
        @(negedge clk);
        run_word(0, 2, 64'h0F1E_2D3C_4B5A_6978, 1, 3, "ignored_start");
    endtask

    task automatic test_mid_reset();
        logic [4:0] outs;
        @(negedge clk);
        set_in(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk);
        #1 set_in(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        // Cycle 83 is the high phase of bit 20 at CLK_DIV=2.
        repeat (83) @(negedge clk);
        outs = {busy0, sclk0, sdat0, pen0, done0};
        checks++; if (outs !== 5'b11100) begin errors++; $display("FAIL pre_reset_state: got %b want %b", outs, 5'b11100); end
        rst_n = 1'b0;
        #1;
        outs = {busy0, sclk0, sdat0, pen0, done0};
        checks++; if (outs !== 5'b0) begin errors++; $display("FAIL mid_reset_outputs: got %b want %b", outs, 5'b0); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_word(0, 2, {$urandom, $urandom}, 0, 3, "after_reset");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_word(1, 1, {$urandom, $urandom}, 0, 2, "b2b_first");
        run_word(1, 1, {$urandom, $urandom}, 0, 3, "b2b_second");
    endtask

    task automatic test_capture_change();
        @(negedge clk);
        run_word(0, 2, {$urandom, $urandom}, 2, 3, "txt_change");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            run_word(0, 2, {$urandom, $urandom}, 0, 1 + i, "random");
        end
    endtask

    initial begin
        test_reset();
        test_marker();
        test_typical();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        test_capture_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_p2s.md
# seg_p2s

Parallel-to-serial transmitter for the 8-digit seven-segment board. It captures a 64-bit segment-text word, which is the output of the hex-to-segment encoder (8 digits × 8 segment bits, active-low segments, point included). It then shifts the word MSB-first into the board's external serial-in/parallel-out shift-register chain, using a divided serial clock and a panel-enable strobe. It sits between the encoder and the board pins and refreshes the display whenever `start` is pulsed.

## Interface
Parameters:
- `CLK_DIV`, default 2: `clk` cycles per half-period of `seg_clk`; must be ≥1.
- `SEG_BITS`, default 64: word width; fixed by the 8-digit chain.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request to transmit; sampled only in IDLE.
- `seg_txt` input 64: segment word; bits [63:56] are digit 7, bit 63 is shifted first.
- `busy` output 1: high while a word is being shifted.
- `done` output 1: one-cycle pulse when the word is fully shifted.
- `seg_clk` output 1: serial shift clock; the external chain samples on its rising edge.
- `seg_dat` output 1: serial data.
- `seg_pen` output 1: panel enable; low blanks the display.

## Operation
- States: IDLE, SHIFT, LATCH.
- **IDLE:**
  - `start`=1 at a rising edge loads `seg_txt` into a 64-bit shift register.
  - Clears the bit counter (6 bits) and the divider counter.
  - Moves to SHIFT.
  - `seg_txt` changes after capture are ignored.
- **SHIFT:** each bit lasts 2·CLK_DIV cycles.
  - `seg_clk`=0 for CLK_DIV cycles, then `seg_clk`=1 for CLK_DIV cycles.
  - `seg_dat` = shift-register MSB; it changes only when `seg_clk` is 0, at bit boundaries.
  - At the end of each high phase, the register shifts left by 1 (zero fill) and the bit counter increments.
  - After bit 63's high phase, the state moves to LATCH.
- **LATCH:** lasts one cycle.
  - `done`=1 and `seg_clk`=0.
  - `seg_pen` rises to 1.
  - Then returns to IDLE.
- `seg_pen` is 0 throughout SHIFT, so the display is blanked during update. It goes to 1 in LATCH and holds 1 in IDLE until the next SHIFT.
- `busy`=1 exactly in SHIFT.
- `start` in SHIFT or LATCH is ignored; no queuing.
- Reset (any time, including mid-SHIFT) aborts immediately.

## Timing
- Reset values:
  - state IDLE
  - `busy`=0, `done`=0
  - `seg_clk`=0, `seg_dat`=0
  - `seg_pen`=0 (display blank until the first completed word)
  - all counters 0, shift register 0
- Let `start` be sampled at edge k:
  - `busy`=1 and `seg_dat`=`seg_txt`[63] from cycle k+1.
  - First `seg_clk` rise is at cycle k+1+CLK_DIV.
  - SHIFT spans 128·CLK_DIV cycles.
  - `done`=1 in cycle k+1+128·CLK_DIV.
  - Earliest accepted restart is the edge ending that cycle +1, i.e. one IDLE cycle minimum between words.
- Setup/hold to the external chain: `seg_dat` is stable for CLK_DIV cycles before and after each `seg_clk` rise.
- Exactly 64 `seg_clk` rising edges per word; no glitches. All outputs are registered.

## Structure
- Package `seg_pkg` holds:
  - the state enum (IDLE/SHIFT/LATCH)
  - `SEG_BITS`=64
  - `SEG_DIGITS`=8
  - the bit-counter width `$clog2(SEG_BITS)`
- One natural sub-module, `clk_tick_gen`: divider counter producing `half_tick` every CLK_DIV cycles. It is cleared on load and is used to toggle `seg_clk` and step the shift register.
- FSM, shift register and output registers live in `seg_p2s`.

## Test plan
- **Marker word:** `seg_txt`=64'h8000_0000_0000_0001, CLK_DIV=2, `start` at edge 10 → exactly 64 rises; first sampled bit 1, bits 2–63 0, bit 64 1. `done` in cycle 10+1+256=267; `seg_pen` 0→1 there.
- **Typical word:** `seg_txt`=64'hA5A5_A5A5_A5A5_A5A5 → the bench's 64-bit serial capture at `seg_clk` rises equals the input. `busy` is high for exactly 256 cycles.
- **Ignored start:** `start` pulsed with `seg_txt`=64'h1234_5678_9ABC_DEF0 while `busy` (bit 20), and again during LATCH → no restart; the captured stream equals the original word. One `done` only.
- **Mid-shift reset:** `rst_n` low at bit 20 → same cycle `busy`=0, `seg_clk`=0, `seg_dat`=0, `seg_pen`=0. After release, a new `start` shifts a full 64 bits.
- **CLK_DIV=1, back-to-back:** starts at edges 5 and 136 → first `done` at cycle 134, the second at 265. `seg_clk` period is 2 cycles.
- **Input changes after capture:** `seg_txt` changes every cycle after the `start` edge → the transmitted word equals the value at the capture edge.
